// File: rtl/uart_pkg.sv
// Shared UART constants: baud setup, default byte width and the TX arbiter state encoding.
package uart_pkg;
    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } tx_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request after rr_ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // rr_ptr itself is visited last, so the previous winner has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[IDX_W-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant, one-cycle tx_start,
// retry on a missing tx_busy response and drop with err_drop after MAX_RETRY re-pulses.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUSY_TIMEOUT = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       active,
    output logic                       err_drop,
    output logic [1:0]                 dbg_state
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    tx_arb_state_t       state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [TIMER_W-1:0]  timer;
    logic [RETRY_W-1:0]  retry;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign active    = (state != IDLE);
    assign dbg_state = state;

    // Handshake: a requester holds req with stable data until its one-cycle ack; the byte is
    // latched on ack, so req/data may change the following cycle. tx_busy high = line occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            timer    <= '0;
            retry    <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= '0;
            err_drop <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            err_drop <= 1'b0;
            case (state)
                IDLE: begin
                    // A busy line in IDLE belongs to someone else; never grant over it.
                    if (!tx_busy && grant_valid) begin
                        tx_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                        owner   <= grant_idx;
                        ack     <= grant;
                        rr_ptr  <= grant_idx;
                        state   <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    timer    <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        timer <= '0;
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= START;
                        end else begin
                            err_drop <= 1'b1;
                            retry    <= '0;
                            state    <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        retry <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a frame-level uart_tx/loopback model and a byte scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FRAME = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [1:0]     owner;
    logic           active;
    logic           err_drop;
    logic [1:0]     dbg_state;

    logic           model_busy, foreign_busy, dead, rx_valid;
    logic [W-1:0]   model_byte, rx_data;
    int             model_cnt;

    int             vectors = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    int             start_cnt = 0, ack_cnt = 0, drop_cnt = 0, zero_run = 0;
    logic           prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (W),
        .BUSY_TIMEOUT (16),
        .MAX_RETRY    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .owner     (owner),
        .active    (active),
        .err_drop  (err_drop),
        .dbg_state (dbg_state)
    );

    // uart_tx stand-in: latches tx_data on tx_start, stays busy FRAME cycles, then loops the byte back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
            model_byte <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (model_busy) begin
                if (model_cnt == 1) begin
                    model_busy <= 1'b0;
                    rx_valid   <= 1'b1;
                    rx_data    <= model_byte;
                end
                model_cnt <= model_cnt - 1;
            end else if (tx_start && !dead) begin
                model_busy <= 1'b1;
                model_cnt  <= FRAME;
                model_byte <= tx_data;
            end
        end
    end

    assign tx_busy = model_busy | foreign_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp, input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (ack == '0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(ack), 32'(exp));
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || active) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
    endtask

    // Scoreboard pop plus per-pulse tx_start properties.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                check("rx_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (tx_start) begin
                start_cnt++;
                check("start_width", 32'(prev_start), 32'(0));
                check("start_gap", 32'(zero_run >= 1), 32'(1));
            end
            ack_cnt += $countones(ack);
            if (err_drop) drop_cnt++;
            zero_run   = tx_busy ? 0 : zero_run + 1;
            prev_start = tx_start;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, s0, i, cyc, nst, prev;
        logic seen;

        rst          = 1'b1;
        req          = '0;
        req_data     = '0;
        foreign_busy = 1'b0;
        dead         = 1'b0;
        tick(2);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        check("rst_err_drop", 32'(err_drop), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(1);

        // All four held: strict rotation starting at requester 0.
        a0 = ack_cnt;
        s0 = start_cnt;
        req_data = 32'h40302010;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h10);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr_ack", 4'(1 << (k % 4)), 40);
            check("rr_owner", 32'(owner), 32'(k % 4));
        end
        req = '0;
        drain("rr_drain");
        check("rr_ack_count", 32'(ack_cnt - a0), 32'(5));
        check("rr_start_count", 32'(start_cnt - s0), 32'(5));

        // Single request: exact ack and tx_start latency.
        req_data = 32'h0000C100;
        exp_q.push_back(8'hC1);
        req = 4'b0010;
        tick(1);
        check("single_ack", 32'(ack), 32'(4'b0010));
        req = '0;
        tick(1);
        check("single_start", 32'(tx_start), 32'(1));
        check("single_data", 32'(tx_data), 32'(8'hC1));
        check("single_owner", 32'(owner), 32'(1));
        tick(1);
        check("single_busy_rise", 32'(tx_busy), 32'(1));
        i = 0;
        while (tx_busy && i < 30) begin
            tick(1);
            i++;
        end
        check("single_active_hold", 32'(active), 32'(1));
        tick(1);
        check("single_active_fall", 32'(active), 32'(0));
        drain("single_drain");

        // Dead uart_tx: four pulses 17 cycles apart, one drop, then the pending requester.
        dead     = 1'b1;
        req_data = 32'h00D2B100;
        req      = 4'b0110;
        wait_ack("dead_first_ack", 4'b0100, 10);
        req  = 4'b0010;
        cyc  = 0;
        nst  = 0;
        prev = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            tick(1);
            cyc++;
            if (tx_start) begin
                if (nst > 0) check("dead_spacing", 32'(cyc - prev), 32'(17));
                prev = cyc;
                nst++;
            end
            if (err_drop) seen = 1'b1;
        end
        check("dead_starts", 32'(nst), 32'(4));
        check("dead_err_drop", 32'(err_drop), 32'(1));
        check("dead_state", 32'(dbg_state), 32'(ST_IDLE));
        dead = 1'b0;
        exp_q.push_back(8'hB1);
        tick(1);
        check("dead_err_single", 32'(err_drop), 32'(0));
        check("dead_next_ack", 32'(ack), 32'(4'b0010));
        req = '0;
        drain("dead_drain");

        // Foreign busy: no grant while the line is occupied.
        foreign_busy = 1'b1;
        req_data     = 32'h0000003C;
        exp_q.push_back(8'h3C);
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("fb_no_ack", 32'(ack), 32'(0));
            check("fb_no_start", 32'(tx_start), 32'(0));
        end
        #1 foreign_busy = 1'b0;
        tick(1);
        check("fb_ack", 32'(ack), 32'(4'b0001));
        req = '0;
        tick(1);
        check("fb_start", 32'(tx_start), 32'(1));
        check("fb_data", 32'(tx_data), 32'(8'h3C));
        drain("fb_drain");

        // Reset in WAIT_DONE, then fairness from a fresh pointer with req=1001 held.
        req_data = 32'h77000000;
        exp_q.push_back(8'h77);
        req = 4'b1000;
        wait_ack("mid_ack", 4'b1000, 10);
        req = '0;
        i = 0;
        while (dbg_state != ST_WAIT_DONE && i < 30) begin
            tick(1);
            i++;
        end
        check("mid_in_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
        exp_q.delete();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 32'(0));
        check("mid_rst_ack", 32'(ack), 32'(0));
        check("mid_rst_active", 32'(active), 32'(0));
        check("mid_rst_owner", 32'(owner), 32'(0));
        check("mid_rst_tx_data", 32'(tx_data), 32'(0));
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        req_data = 32'h6B00005A;
        req      = 4'b1001;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h6B);
        exp_q.push_back(8'h5A);
        tick(2);
        rst = 1'b0;
        wait_ack("fair_first", 4'b0001, 10);
        wait_ack("fair_second", 4'b1000, 40);
        wait_ack("fair_third", 4'b0001, 40);
        req = '0;
        drain("fair_drain");

        check("drop_total", 32'(drop_cnt), 32'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
